// File: rtl/controle_ula_if.sv
// rtl/controle_ula_if.sv - instruction handshake and register/ULA control bundle for controle_ula
// Optional instr_count signal present when CONTROLE_INSTR_COUNT_EN is defined.
interface controle_ula_if #(
  parameter int WIDTH = 4
);
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       instr_opcode;
  logic [WIDTH-1:0] instr_dado;
  logic [WIDTH-1:0] barramento;
  logic [1:0]       Tx;
  logic [1:0]       Ty;
  logic [1:0]       Tz;
  logic [1:0]       ula_sel;
  logic             done;
  logic             erro;
`ifdef CONTROLE_INSTR_COUNT_EN
  logic [7:0]       instr_count;

  modport slave (
    input  instr_valid, instr_opcode, instr_dado,
    output instr_ready, barramento, Tx, Ty, Tz, ula_sel, done, erro, instr_count
  );
  modport master (
    output instr_valid, instr_opcode, instr_dado,
    input  instr_ready, barramento, Tx, Ty, Tz, ula_sel, done, erro, instr_count
  );
`else
  modport slave (
    input  instr_valid, instr_opcode, instr_dado,
    output instr_ready, barramento, Tx, Ty, Tz, ula_sel, done, erro
  );
  modport master (
    output instr_valid, instr_opcode, instr_dado,
    input  instr_ready, barramento, Tx, Ty, Tz, ula_sel, done, erro
  );
`endif
endinterface

// File: rtl/controle_ula.sv
// rtl/controle_ula.sv - Moore instruction sequencer driving X/Y/Z control codes and ULA select
// Optional retired-instruction counter enabled by CONTROLE_INSTR_COUNT_EN.
module controle_ula #(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input logic           clock,
  input logic           reset,
  controle_ula_if.slave bus
);
  localparam logic [1:0] T_CLEAR = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_HOLD  = 2'd2;
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("controle_ula: EXEC_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOAD, S_CLEAR, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       opcode_q;
  logic [WIDTH-1:0] dado_q;
  logic [1:0]       sel_q;
  logic [3:0]       cnt_q;
  logic             ready;
  logic             accept;
  logic [1:0]       tx, ty, tz;
  logic [WIDTH-1:0] bus_d;

  assign ready  = (state == S_IDLE) && !reset;
  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      opcode_q <= '0;
      dado_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        opcode_q <= bus.instr_opcode;
        dado_q   <= bus.instr_dado;
      end
      // ula_sel is latched on EXEC entry so it persists after the operation
      if (state == S_DECODE && state_n == S_EXEC) begin
        sel_q <= opcode_q[1:0];
        cnt_q <= EXEC_LAST;
      end else if (state == S_EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (accept) state_n = S_DECODE;
      S_DECODE: begin
        if (opcode_q == 4'd1 || opcode_q == 4'd2) state_n = S_LOAD;
        else if (opcode_q == 4'd3)                state_n = S_CLEAR;
        else if (opcode_q[3:2] == 2'b01)          state_n = S_EXEC;
        else                                      state_n = S_DONE;
      end
      S_LOAD, S_CLEAR, S_WRITE: state_n = S_DONE;
      S_EXEC:   if (cnt_q == 4'd0) state_n = S_WRITE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Reset forces CLEAR so the external registers clear on every edge it is held
  always_comb begin
    tx    = T_HOLD;
    ty    = T_HOLD;
    tz    = T_HOLD;
    bus_d = '0;
    if (reset) begin
      tx = T_CLEAR;
      ty = T_CLEAR;
      tz = T_CLEAR;
    end else begin
      case (state)
        S_LOAD: begin
          bus_d = dado_q;
          if (opcode_q[1:0] == 2'd1) tx = T_LOAD;
          else                       ty = T_LOAD;
        end
        S_CLEAR: begin
          tx = T_CLEAR;
          ty = T_CLEAR;
          tz = T_CLEAR;
        end
        S_WRITE: tz = T_LOAD;
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = ready;
  assign bus.barramento  = bus_d;
  assign bus.Tx          = tx;
  assign bus.Ty          = ty;
  assign bus.Tz          = tz;
  assign bus.ula_sel     = sel_q;
  assign bus.done        = (state == S_DONE);
  assign bus.erro        = (state == S_DONE) && opcode_q[3];

`ifdef CONTROLE_INSTR_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= 8'd0;
    else if (state == S_DONE) count_q <= count_q + 8'd1;
  end

  assign bus.instr_count = count_q;
`endif
endmodule

// File: tb/tb_controle_ula.sv
// tb/tb_controle_ula.sv - self-checking bench for controle_ula (EXEC_CYCLES=2)
// Covers CONTROLE_INSTR_COUNT_EN when the macro is defined.
module tb_controle_ula;
  localparam int W  = 4;
  localparam int EC = 2;
  localparam logic [1:0] C = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] H = 2'd2;

  typedef struct packed {
    logic         ready;
    logic [1:0]   tx;
    logic [1:0]   ty;
    logic [1:0]   tz;
    logic [W-1:0] bus;
    logic [1:0]   sel;
    logic         done;
    logic         erro;
  } obs_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] dado;
    int         occ;
    bit         erro;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [1:0] model_sel = 2'd0;
  obs_t trace[$];

  controle_ula_if #(.WIDTH(W)) bus_if ();

  controle_ula #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  function automatic obs_t mk(input logic r, input logic [1:0] x, input logic [1:0] y,
                              input logic [1:0] z, input logic [W-1:0] b, input logic [1:0] s,
                              input logic d, input logic e);
    obs_t o;
    o.ready = r; o.tx = x; o.ty = y; o.tz = z; o.bus = b; o.sel = s; o.done = d; o.erro = e;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus_if.instr_ready, bus_if.Tx, bus_if.Ty, bus_if.Tz, bus_if.barramento,
              bus_if.ula_sel, bus_if.done, bus_if.erro);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rdy=%0d Tx=%0d Ty=%0d Tz=%0d bus=%h sel=%0d done=%0d erro=%0d",
                     o.ready, o.tx, o.ty, o.tz, o.bus, o.sel, o.done, o.erro);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual {%s} required {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: per-cycle outputs after the accept edge, ending with the ready cycle
  task automatic build_trace(input logic [3:0] op, input logic [3:0] d);
    int code;
    code = int'(op);
    trace.delete();
    trace.push_back(mk(0, H, H, H, '0, model_sel, 0, 0));
    if (code == 1 || code == 2) begin
      trace.push_back(mk(0, (code == 1) ? L : H, (code == 2) ? L : H, H, d, model_sel, 0, 0));
    end else if (code == 3) begin
      trace.push_back(mk(0, C, C, C, '0, model_sel, 0, 0));
    end else if (code >= 4 && code <= 7) begin
      model_sel = 2'(code % 4);
      for (int k = 0; k < EC; k++) trace.push_back(mk(0, H, H, H, '0, model_sel, 0, 0));
      trace.push_back(mk(0, H, H, L, '0, model_sel, 0, 0));
    end
    trace.push_back(mk(0, H, H, H, '0, model_sel, 1, code >= 8));
    trace.push_back(mk(1, H, H, H, '0, model_sel, 0, 0));
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] d,
                           output int occ, output bit saw_erro);
    int   waited;
    obs_t o;
    waited = 0;
    occ = -1;
    saw_erro = 0;
    @(negedge clock);
    while (!bus_if.instr_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check_val("ready_before_issue", int'(bus_if.instr_ready), 1);
    build_trace(op, d);
    bus_if.instr_valid  = 1'b1;
    bus_if.instr_opcode = op;
    bus_if.instr_dado   = d;
    @(posedge clock);
    #1;
    bus_if.instr_valid  = 1'b0;
    bus_if.instr_opcode = 4'($urandom);
    bus_if.instr_dado   = W'($urandom);
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clock);
      o = sample();
      if (o.ready && occ < 0) occ = i;
      if (o.erro) saw_erro = 1;
      check_obs($sformatf("op%0d_d%h_cyc%0d", op, d, i), o, trace[i]);
    end
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   occ;
    bit   se;
    bit   saw_tz, saw_done;
    obs_t o;

    vecs[0] = '{4'h1, 4'hA, 3, 0};
    vecs[1] = '{4'h2, 4'h3, 3, 0};
    vecs[2] = '{4'h5, 4'h0, 3 + EC, 0};
    vecs[3] = '{4'hC, 4'h6, 2, 1};
    vecs[4] = '{4'h0, 4'h7, 2, 0};
    vecs[5] = '{4'h3, 4'h1, 3, 0};
    vecs[6] = '{4'h4, 4'hF, 3 + EC, 0};
    vecs[7] = '{4'h7, 4'h2, 3 + EC, 0};
    vecs[8] = '{4'hF, 4'h9, 2, 1};
    vecs[9] = '{4'h6, 4'h5, 3 + EC, 0};

    // Reset held with a pending instruction
    bus_if.instr_valid  = 1'b1;
    bus_if.instr_opcode = 4'h1;
    bus_if.instr_dado   = 4'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_obs($sformatf("reset_cyc%0d", i), sample(), mk(0, C, C, C, '0, 2'd0, 0, 0));
    end
    reset = 1'b0;
    bus_if.instr_valid = 1'b0;
    @(negedge clock);
    check_obs("after_reset", sample(), mk(1, H, H, H, '0, 2'd0, 0, 0));

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].dado, occ, se);
      check_val($sformatf("occ_op%0d", vecs[i].op), occ, vecs[i].occ);
      check_val($sformatf("erro_op%0d", vecs[i].op), int'(se), int'(vecs[i].erro));
    end

    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom_range(0, 15)), 4'($urandom), occ, se);
    end

    // Reset during EXEC of opcode 7
    @(negedge clock);
    bus_if.instr_valid  = 1'b1;
    bus_if.instr_opcode = 4'h7;
    bus_if.instr_dado   = 4'h0;
    @(posedge clock);
    #1;
    bus_if.instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_val("midexec_sel", int'(bus_if.ula_sel), 3);
    reset = 1'b1;
    #1;
    check_obs("midexec_in_reset", sample(), mk(0, C, C, C, '0, 2'd0, 0, 0));
    @(negedge clock);
    reset = 1'b0;
    model_sel = 2'd0;
    saw_tz = 0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      o = sample();
      if (o.tz == L) saw_tz = 1;
      if (o.done) saw_done = 1;
      if (i == 0) check_obs("midexec_release", o, mk(1, H, H, H, '0, 2'd0, 0, 0));
    end
    check_val("midexec_no_tz_load", int'(saw_tz), 0);
    check_val("midexec_no_done", int'(saw_done), 0);

    run_instr(4'h2, 4'h3, occ, se);
    check_val("post_reset_ldy_occ", occ, 3);

`ifdef CONTROLE_INSTR_COUNT_EN
    begin
      int accepts, dones, guard;
      logic [7:0] base;
      @(negedge clock);
      base = bus_if.instr_count;
      accepts = 0;
      dones = 0;
      guard = 0;
      bus_if.instr_opcode = 4'h0;
      bus_if.instr_valid  = 1'b1;
      while (accepts < 257 && guard < 2000) begin
        if (bus_if.instr_ready) accepts++;
        if (accepts == 257) begin
          @(posedge clock);
          #1;
          bus_if.instr_valid = 1'b0;
        end
        @(negedge clock);
        if (bus_if.done) dones++;
        guard++;
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        if (bus_if.done) dones++;
      end
      check_val("nop_accepts", accepts, 257);
      check_val("nop_dones", dones, 257);
      check_val("instr_count_wrap", int'(bus_if.instr_count), int'(8'(base + 8'd1)));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
